// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the iterative cipher core.
package aes_pkg;

  localparam int NR_128 = 10;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column is {a0, a1, a2, a3} with a0 in the top byte (row 0).
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         final_rnd,
  output logic [127:0] state_out
);

  logic [127:0] sub;
  logic [127:0] shf;
  logic [127:0] mix;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_in  (state_in[127-8*i -: 8]),
      .byte_out (sub[127-8*i -: 8])
    );
  end

  // Byte index is row + 4*col; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shf[127-8*(r+4*c) -: 8] = sub[127-8*(r+4*((c+r)%4)) -: 8];
    end
    assign mix[127-32*c -: 32] = mix_col(shf[127-32*c -: 32]);
  end

  assign state_out = (final_rnd ? shf : mix) ^ rk;

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box as a combinational 256-entry lookup.
module aes_sbox (
  input  logic [7:0] byte_in,
  output logic [7:0] byte_out
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign byte_out = SBOX[byte_in];

endmodule

// File: rtl/aes_cipher_kx.sv
// Iterative AES-128/256 encryption core, one round per clock, on-the-fly key expansion.
module aes_cipher_kx
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_BITS-1:0] key,
  input  logic [127:0]        text_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        text_out,
  output logic                busy,
  output logic [3:0]          round_cnt
);

  localparam int NR = (KEY_BITS == 256) ? NR_256 : NR_128;
  localparam logic [3:0] NR_L = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_cipher_kx: KEY_BITS must be 128 or 256");
  end

  state_t              fsm_q, fsm_d;
  logic [127:0]        state_q, state_d;
  logic [127:0]        text_out_q, text_out_d;
  logic [KEY_BITS-1:0] kreg_q, kreg_d;
  logic [3:0]          round_cnt_q, round_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic [31:0]         sub_word;
  logic [31:0]         temp_word;
  logic [127:0]        prev_rk;
  logic [127:0]        nxt_rk;
  logic [127:0]        rk_cur;
  logic [127:0]        rk0;
  logic [127:0]        round_out;
  logic [KEY_BITS-1:0] kreg_adv;
  logic                rot_en;
  logic [7:0]          rc;
  logic                last_rnd;
  logic                accept;

  // The word feeding SubWord is always the last word of kreg for both key sizes.
  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (
      .byte_in  (kreg_q[31-8*j -: 8]),
      .byte_out (sub_word[31-8*j -: 8])
    );
  end

  assign prev_rk = kreg_q[KEY_BITS-1 -: 128];

  if (KEY_BITS == 256) begin : g_ks256
    logic [4:0] rnd_p1;
    assign rnd_p1   = {1'b0, round_cnt_q} + 5'd1;
    assign rot_en   = ~rnd_p1[0];
    assign rc       = rcon(rnd_p1[4:1]);
    assign rk_cur   = kreg_q[127:0];
    assign kreg_adv = {kreg_q[127:0], nxt_rk};
    assign rk0      = key[255:128];
  end else begin : g_ks128
    assign rot_en   = 1'b1;
    assign rc       = rcon(round_cnt_q);
    assign rk_cur   = nxt_rk;
    assign kreg_adv = nxt_rk;
    assign rk0      = key[127:0];
  end

  always_comb begin
    logic [31:0] w0, w1, w2, w3;
    temp_word = rot_en ? ({sub_word[23:0], sub_word[31:24]} ^ {rc, 24'h0}) : sub_word;
    w0 = prev_rk[127:96] ^ temp_word;
    w1 = prev_rk[95:64]  ^ w0;
    w2 = prev_rk[63:32]  ^ w1;
    w3 = prev_rk[31:0]   ^ w2;
    nxt_rk = {w0, w1, w2, w3};
  end

  assign last_rnd = (round_cnt_q == NR_L);

  aes_round u_round (
    .state_in  (state_q),
    .rk        (rk_cur),
    .final_rnd (last_rnd),
    .state_out (round_out)
  );

  assign in_ready = ~rst & ((fsm_q == IDLE) | ((fsm_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    kreg_d      = kreg_q;
    text_out_d  = text_out_q;
    round_cnt_d = round_cnt_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (fsm_q)
      IDLE: ;
      RUN: begin
        state_d = round_out;
        kreg_d  = kreg_adv;
        if (last_rnd) begin
          text_out_d  = round_out;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          fsm_d       = DONE;
        end else begin
          round_cnt_d = round_cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          round_cnt_d = 4'd0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
    // An accept in DONE overrides the return to IDLE: handshake and load share the edge.
    if (accept) begin
      state_d     = text_in ^ rk0;
      kreg_d      = key;
      round_cnt_d = 4'd1;
      busy_d      = 1'b1;
      fsm_d       = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      text_out_q  <= '0;
      round_cnt_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      text_out_q  <= text_out_d;
      round_cnt_q <= round_cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    kreg_q  <= kreg_d;
  end

  assign out_valid = out_valid_q;
  assign text_out  = text_out_q;
  assign busy      = busy_q;
  assign round_cnt = round_cnt_q;

endmodule

// File: tb/tb_aes_cipher_kx.sv
// Directed bench for aes_cipher_kx using FIPS-197 known-answer vectors at both key sizes.
module tb_aes_cipher_kx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [127:0] a_key, a_text_in, a_text_out;
  logic [3:0]   a_round_cnt;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [255:0] b_key;
  logic [127:0] b_text_in, b_text_out;
  logic [3:0]   b_round_cnt;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PF  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CF  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  aes_cipher_kx #(.KEY_BITS(128)) u_dut128 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .key       (a_key),
    .text_in   (a_text_in),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .text_out  (a_text_out),
    .busy      (a_busy),
    .round_cnt (a_round_cnt)
  );

  aes_cipher_kx #(.KEY_BITS(256)) u_dut256 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .key       (b_key),
    .text_in   (b_text_in),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .text_out  (b_text_out),
    .busy      (b_busy),
    .round_cnt (b_round_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a block to the 128-bit core and return right after its accept edge.
  task automatic send_a(input logic [127:0] k, input logic [127:0] pt);
    int n;
    a_key = k;
    a_text_in = pt;
    a_in_valid = 1'b1;
    n = 0;
    while (!a_in_ready && n < 40) begin
      step();
      n++;
    end
    chk("a_ready_before_accept", a_in_ready, 1);
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic wait_a(output int n);
    n = 0;
    while (1) begin
      step();
      n++;
      if (a_out_valid || n >= 40) break;
    end
  endtask

  task automatic wait_b(output int n);
    n = 0;
    while (1) begin
      step();
      n++;
      if (b_out_valid || n >= 40) break;
    end
  endtask

  initial begin
    int lat;
    logic seen;
    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_key = '0; a_text_in = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_key = '0; b_text_in = '0;
    a_in_valid = 1'b1;
    repeat (3) step();

    // Reset state: in_ready forced low while rst is high, even with in_valid set.
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_round_cnt", a_round_cnt, 0);
    chk("rst_text_out", a_text_out, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_round_cnt", b_round_cnt, 0);
    a_in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("idle_in_ready", a_in_ready, 1);
    chk("idle_b_in_ready", b_in_ready, 1);

    // FIPS-197 C.1, AES-128.
    a_out_ready = 1'b1;
    send_a(K1, P1);
    chk("c1_busy_after_accept", a_busy, 1);
    chk("c1_round_cnt_after_accept", a_round_cnt, 1);
    chk("c1_in_ready_run", a_in_ready, 0);
    wait_a(lat);
    chk("c1_latency", lat, 10);
    chk("c1_ct", a_text_out, C1);
    chk("c1_done_busy", a_busy, 0);
    chk("c1_done_round_cnt", a_round_cnt, 10);
    step();
    chk("c1_release_out_valid", a_out_valid, 0);
    chk("c1_release_round_cnt", a_round_cnt, 0);

    // FIPS-197 C.3, AES-256.
    b_out_ready = 1'b1;
    b_key = K3;
    b_text_in = P1;
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    chk("c3_busy_after_accept", b_busy, 1);
    wait_b(lat);
    chk("c3_latency", lat, 14);
    chk("c3_ct", b_text_out, C3);
    chk("c3_done_round_cnt", b_round_cnt, 14);
    step();
    chk("c3_release_out_valid", b_out_valid, 0);

    // Backpressure: result must hold while out_ready is low.
    a_out_ready = 1'b0;
    send_a(KB, PB);
    wait_a(lat);
    chk("bp_latency", lat, 10);
    chk("bp_ct", a_text_out, CB);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_hold_ct", a_text_out, CB);
      chk("bp_hold_valid", a_out_valid, 1);
      chk("bp_in_ready", a_in_ready, 0);
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", a_in_ready, 1);
    step();
    chk("bp_release_out_valid", a_out_valid, 0);

    // Back-to-back: in_valid stays high over three blocks.
    a_key = K1;
    a_text_in = P1;
    a_in_valid = 1'b1;
    chk("b2b_ready_a", a_in_ready, 1);
    step();
    a_key = KB;
    a_text_in = PB;
    wait_a(lat);
    chk("b2b_lat_a", lat, 10);
    chk("b2b_ct_a", a_text_out, C1);
    chk("b2b_ready_at_done_a", a_in_ready, 1);
    step();
    chk("b2b_handshake_a_valid", a_out_valid, 0);
    chk("b2b_accept_b_busy", a_busy, 1);
    chk("b2b_accept_b_round", a_round_cnt, 1);
    a_text_in = PF;
    wait_a(lat);
    chk("b2b_lat_b", lat, 10);
    chk("b2b_ct_b", a_text_out, CB);
    chk("b2b_ready_at_done_b", a_in_ready, 1);
    step();
    a_in_valid = 1'b0;
    chk("b2b_accept_c_round", a_round_cnt, 1);
    chk("b2b_handshake_b_valid", a_out_valid, 0);
    wait_a(lat);
    chk("b2b_lat_c", lat, 10);
    chk("b2b_ct_c", a_text_out, CF);
    step();
    chk("b2b_idle_valid", a_out_valid, 0);
    chk("b2b_idle_round", a_round_cnt, 0);

    // Inputs changed during RUN must not disturb the block in flight.
    send_a(K1, P1);
    a_key = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
    a_text_in = 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a;
    a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ign_in_ready", a_in_ready, 0);
    end
    a_in_valid = 1'b0;
    wait_a(lat);
    chk("ign_lat_rest", lat, 5);
    chk("ign_ct", a_text_out, C1);
    step();

    // Reset during round 5 aborts the block and clears the output.
    send_a(KB, PB);
    repeat (4) step();
    chk("abort_round5", a_round_cnt, 5);
    rst = 1'b1;
    step();
    chk("abort_out_valid", a_out_valid, 0);
    chk("abort_busy", a_busy, 0);
    chk("abort_round_cnt", a_round_cnt, 0);
    chk("abort_text_out", a_text_out, 0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", a_in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (a_out_valid) seen = 1'b1;
    end
    chk("abort_no_out_valid", seen, 0);
    send_a(K1, P1);
    wait_a(lat);
    chk("post_abort_latency", lat, 10);
    chk("post_abort_ct", a_text_out, C1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
